// File: rtl/uart_rx_pkg.sv
// Shared widths, limits and helpers for the UART receiver front end.
// Used by uart_rx_data_sampler and uart_rx_edge_bit_counter.
package uart_rx_pkg;

    localparam int EDGE_W    = 5;
    localparam int BIT_W     = 4;
    localparam int PRESC_W   = 6;
    localparam int PRESC_MIN = 6;
    localparam int PRESC_MAX = 32;

    localparam logic LINE_IDLE = 1'b1;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Per-bit oversample counter and frame bit counter.
// Prescale is latched while idle so a frame keeps one bit period.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               enable,
    output logic [PRESC_W-1:0] pq,
    output logic [EDGE_W-1:0]  edge_count,
    output logic [BIT_W-1:0]   bit_count
);

    logic [PRESC_W-1:0] last_edge;
    logic [PRESC_W-1:0] edge_ext;

    // pq of zero behaves as one: the counter never leaves 0
    assign last_edge = (pq == '0) ? '0 : pq - PRESC_W'(1);
    assign edge_ext  = {1'b0, edge_count};

    always_ff @(posedge clk) begin
        if (!rst) begin
            pq         <= Prescale;
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!enable) begin
            pq         <= Prescale;
            edge_count <= '0;
            bit_count  <= '0;
        end else if (edge_ext == last_edge) begin
            edge_count <= '0;
            bit_count  <= bit_count + BIT_W'(1);
        end else begin
            edge_count <= edge_count + EDGE_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART RX oversampling front end: line conditioning, counters, 3-sample vote.
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer on RX_IN.
module uart_rx_data_sampler
    import uart_rx_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               enable,
    output logic               rx_line,
    output logic [EDGE_W-1:0]  edge_count,
    output logic [BIT_W-1:0]   bit_count,
    output logic               sampled_bit,
    output logic               sample_valid
);

    logic [PRESC_W-1:0] pq;
    logic [PRESC_W-1:0] mid;
    logic [PRESC_W-1:0] edge_ext;
    logic               s0;
    logic               s1;

`ifdef UART_RX_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= LINE_IDLE;
            sync2 <= LINE_IDLE;
        end else begin
            sync1 <= RX_IN;
            sync2 <= sync1;
        end
    end

    assign rx_line = sync2;
`else
    assign rx_line = RX_IN;
`endif

    uart_rx_edge_bit_counter u_cnt (
        .clk        (clk),
        .rst        (rst),
        .Prescale   (Prescale),
        .enable     (enable),
        .pq         (pq),
        .edge_count (edge_count),
        .bit_count  (bit_count)
    );

    assign mid      = pq >> 1;
    assign edge_ext = {1'b0, edge_count};

    // Samples at mid-1, mid, mid+1; vote lands at mid+1
    always_ff @(posedge clk) begin
        if (!rst) begin
            s0           <= LINE_IDLE;
            s1           <= LINE_IDLE;
            sampled_bit  <= LINE_IDLE;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (enable) begin
                if (edge_ext == mid - PRESC_W'(1)) begin
                    s0 <= rx_line;
                end
                if (edge_ext == mid) begin
                    s1 <= rx_line;
                end
                if (edge_ext == mid + PRESC_W'(1)) begin
                    sampled_bit  <= maj3(s0, s1, rx_line);
                    sample_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Randomized + directed bench for uart_rx_data_sampler.
// Reference model tracks cycles-into-frame and derives outputs arithmetically.
module tb_uart_rx_data_sampler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       enable = 1'b0;
    logic       rx_line;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic       sampled_bit;
    logic       sample_valid;

    uart_rx_data_sampler dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .enable       (enable),
        .rx_line      (rx_line),
        .edge_count   (edge_count),
        .bit_count    (bit_count),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    bit armed  = 1'b0;

    // model state: cycles since frame start, latched prescale
    int   c  = 0;
    int   mp = 8;
    logic ms = 1'b1;
    logic mv = 1'b0;
    logic l1 = 1'b1;
    logic l2 = 1'b1;
    logic y1 = 1'b1;
    logic y2 = 1'b1;
    logic ml = 1'b1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int per();
        return (mp == 0) ? 1 : mp;
    endfunction

    task automatic model(input logic r, input logic e, input logic [5:0] p,
                         input logic x);
        logic ln;
        int   ed;
        int   m;
        ln = (LAT == 2) ? y2 : x;
        if (!r) begin
            c  = 0;
            mp = int'(p);
            ms = 1'b1;
            mv = 1'b0;
        end else if (!e) begin
            c  = 0;
            mp = int'(p);
            mv = 1'b0;
        end else begin
            ed = c % per();
            m  = mp / 2;
            mv = 1'b0;
            if (ed == m + 1) begin
                ms = (l2 & l1) | (l2 & ln) | (l1 & ln);
                mv = 1'b1;
            end
            l2 = l1;
            l1 = ln;
            c++;
        end
        if (!r) begin
            y1 = 1'b1;
            y2 = 1'b1;
        end else begin
            y2 = y1;
            y1 = x;
        end
        ml = (LAT == 2) ? y2 : x;
    endtask

    task automatic step(input logic r, input logic e, input logic [5:0] p,
                        input logic x);
        @(negedge clk);
        if (armed) begin
            check("edge_count", 32'(edge_count), 32'(c % per()));
            check("bit_count", 32'(bit_count), 32'((c / per()) % 16));
            check("sample_valid", 32'(sample_valid), 32'(mv));
            check("sampled_bit", 32'(sampled_bit), 32'(ms));
            check("rx_line", 32'(rx_line), 32'(ml));
            if (sample_valid === 1'b1) pulses++;
        end
        rst      = r;
        enable   = e;
        Prescale = p;
        RX_IN    = x;
        model(r, e, p, x);
        armed = 1'b1;
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       en;
        logic [5:0] p;
        logic       x;
        int         left;
        logic       keep;

        // reset
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 6'd8, 1'b1);
        step(1'b1, 1'b0, 6'd8, 1'b1);
        peek();
        check("rst_edge", 32'(edge_count), 32'd0);
        check("rst_bit", 32'(bit_count), 32'd0);
        check("rst_sbit", 32'(sampled_bit), 32'd1);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_line", 32'(rx_line), 32'd1);

        // prescale 8, three full bits
        pulses = 0;
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 6'd8, 1'b1);
        peek();
        check("p8_bit", 32'(bit_count), 32'd3);
        check("p8_edge", 32'(edge_count), 32'd0);
        step(1'b1, 1'b0, 6'd16, 1'b1);
        check("p8_pulses", 32'(pulses), 32'd3);

        // prescale 16: single-edge glitch, then two-edge low
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, 6'd16, (i == 8 - LAT) ? 1'b0 : 1'b1);
        peek();
        check("glitch_1", 32'(sampled_bit), 32'd1);
        for (int i = 16; i < 32; i++)
            step(1'b1, 1'b1, 6'd16,
                 (i == 23 - LAT || i == 24 - LAT) ? 1'b0 : 1'b1);
        peek();
        check("two_low_0", 32'(sampled_bit), 32'd0);

        // prescale 8 -> 32 mid-frame
        step(1'b1, 1'b0, 6'd8, 1'b1);
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, (i < 4) ? 6'd8 : 6'd32, 1'b1);
        peek();
        check("frozen_bit", 32'(bit_count), 32'd2);
        step(1'b1, 1'b0, 6'd32, 1'b1);
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b1, 6'd32, (i % 5 == 0) ? 1'b0 : 1'b1);
        peek();
        check("p32_edge", 32'(edge_count), 32'd8);
        check("p32_bit", 32'(bit_count), 32'd1);

        // enable drop at edge 5, prescale 16
        step(1'b1, 1'b0, 6'd16, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 6'd16, 1'b0);
        keep = ms;
        step(1'b1, 1'b0, 6'd16, 1'b0);
        peek();
        check("drop_edge", 32'(edge_count), 32'd0);
        check("drop_valid", 32'(sample_valid), 32'd0);
        check("drop_sbit", 32'(sampled_bit), 32'(keep));

        // prescale 0 behaves as 1
        step(1'b1, 1'b0, 6'd0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 6'd0, 1'b1);
        peek();
        check("p0_bit", 32'(bit_count), 32'd5);
        check("p0_edge", 32'(edge_count), 32'd0);

        // rx_line latency
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 6'd8, 1'b1);
        step(1'b1, 1'b0, 6'd8, 1'b0);
`ifdef UART_RX_SYNC_EN
        peek();
        check("sync_lat1", 32'(rx_line), 32'd1);
        step(1'b1, 1'b0, 6'd8, 1'b0);
        peek();
        check("sync_lat2", 32'(rx_line), 32'd0);
`else
        #1;
        check("comb_lat", 32'(rx_line), 32'd0);
`endif

        // random frames, prescale changes, line noise, occasional reset
        left = 0;
        p    = 6'd16;
        x    = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (left == 0) begin
                en   = ~en;
                left = en ? int'($urandom_range(20, 200))
                          : int'($urandom_range(1, 4));
            end
            left--;
            if ($urandom_range(0, 30) == 0)
                p = 6'(6 + 2 * $urandom_range(0, 13));
            if ($urandom_range(0, 3) == 0) x = ~x;
            step(($urandom_range(0, 300) != 0), en, p, x);
        end
        step(1'b1, 1'b0, p, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
